// File: rtl/aud_pkg.sv
// Shared types and defaults for the audio recorder/player sequencer.
package aud_pkg;

  // Sequencer states. The encoding is visible on the debug LEDs, so it is fixed.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_PAUSE  = 3'd2,
    S_PLAY       = 3'd3,
    S_PLAY_PAUSE = 3'd4
  } state_t;

  localparam int                    AUD_ADDR_W   = 20;
  localparam logic [AUD_ADDR_W-1:0] AUD_MAX_ADDR = 20'hFFFFF;

endpackage

// File: rtl/aud_sram_mux.sv
// Registered SRAM address / write-enable mux, keyed by the sequencer state.
module aud_sram_mux
  import aud_pkg::*;
#(
  parameter int ADDR_W = AUD_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  state_t            state,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic [ADDR_W-1:0] play_addr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n
);

  // Route the owning engine's address to the SRAM; only active recording writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr <= '0;
      sram_we_n <= 1'b1;
    end else begin
      case (state)
        S_REC: begin
          sram_addr <= rec_addr;
          sram_we_n <= 1'b0;
        end
        S_REC_PAUSE: begin
          sram_addr <= rec_addr;
          sram_we_n <= 1'b1;
        end
        S_PLAY, S_PLAY_PAUSE: begin
          sram_addr <= play_addr;
          sram_we_n <= 1'b1;
        end
        default: begin
          sram_addr <= '0;
          sram_we_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/aud_rec_play_ctrl.sv
// Top-level record/playback sequencer: turns key pulses into one-cycle
// engine commands, owns the shared SRAM port and remembers the recording end.
module aud_rec_play_ctrl
  import aud_pkg::*;
#(
  parameter int                ADDR_W   = AUD_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(AUD_MAX_ADDR)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic [2:0]        o_state
);

  state_t state;

  assign o_state = state;

  // Sequencer: key priority stop > pause > rec > play; pulses last one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      o_rec_start  <= 1'b0;
      o_rec_pause  <= 1'b0;
      o_rec_stop   <= 1'b0;
      o_play_start <= 1'b0;
      o_play_pause <= 1'b0;
      o_play_stop  <= 1'b0;
      o_end_addr   <= '0;
    end else begin
      o_rec_start  <= 1'b0;
      o_rec_pause  <= 1'b0;
      o_rec_stop   <= 1'b0;
      o_play_start <= 1'b0;
      o_play_pause <= 1'b0;
      o_play_stop  <= 1'b0;
      case (state)
        S_IDLE: begin
          // An empty recording (end address 0) leaves nothing to play.
          if (i_key_rec) begin
            state       <= S_REC;
            o_rec_start <= 1'b1;
          end else if (i_key_play && (o_end_addr != '0)) begin
            state        <= S_PLAY;
            o_play_start <= 1'b1;
          end
        end
        S_REC: begin
          // Memory-full auto-stop yields to an explicit pause in the same cycle.
          if (i_key_stop) begin
            state      <= S_IDLE;
            o_rec_stop <= 1'b1;
            o_end_addr <= i_rec_addr;
          end else if (i_key_pause) begin
            state       <= S_REC_PAUSE;
            o_rec_pause <= 1'b1;
          end else if (i_rec_addr == MAX_ADDR) begin
            state      <= S_IDLE;
            o_rec_stop <= 1'b1;
            o_end_addr <= i_rec_addr;
          end
        end
        S_REC_PAUSE: begin
          if (i_key_stop) begin
            state      <= S_IDLE;
            o_rec_stop <= 1'b1;
            o_end_addr <= i_rec_addr;
          end else if (i_key_pause) begin
            state       <= S_REC;
            o_rec_pause <= 1'b1;
          end
        end
        S_PLAY: begin
          // End-of-recording acts like a stop but yields to a pause key.
          if (i_key_stop) begin
            state       <= S_IDLE;
            o_play_stop <= 1'b1;
          end else if (i_key_pause) begin
            state        <= S_PLAY_PAUSE;
            o_play_pause <= 1'b1;
          end else if (i_play_addr >= o_end_addr) begin
            state       <= S_IDLE;
            o_play_stop <= 1'b1;
          end
        end
        S_PLAY_PAUSE: begin
          if (i_key_stop) begin
            state       <= S_IDLE;
            o_play_stop <= 1'b1;
          end else if (i_key_pause) begin
            state        <= S_PLAY;
            o_play_pause <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  aud_sram_mux #(
    .ADDR_W(ADDR_W)
  ) u_sram_mux (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .state    (state),
    .rec_addr (i_rec_addr),
    .play_addr(i_play_addr),
    .sram_addr(o_sram_addr),
    .sram_we_n(o_sram_we_n)
  );

endmodule
